// File: rtl/mem_arbiter_if.sv
// Signal bundle between the split I/D front end, the arbiter and the single memory port.
// The slave modport is the arbiter's view; master is the surrounding CPU plus memory.
interface mem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             i_read;
    logic [WIDTH-1:0] i_address;
    logic [WIDTH-1:0] i_rdata;
    logic             i_resp;

    logic             d_read;
    logic             d_write;
    logic [3:0]       d_byte_enable;
    logic [WIDTH-1:0] d_address;
    logic [WIDTH-1:0] d_wdata;
    logic [WIDTH-1:0] d_rdata;
    logic             d_resp;

    logic             mem_read;
    logic             mem_write;
    logic [3:0]       mem_byte_enable;
    logic [WIDTH-1:0] mem_address;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_resp;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_byte_enable, d_address, d_wdata,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_byte_enable, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one registered mp2-style memory port between an
// instruction-fetch requester and a data requester, one transaction at a time.
module mem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;   // 0 = I, 1 = D
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic req_i, req_d, grant_i, grant_d;

    assign req_i   = bus.i_read;
    assign req_d   = bus.d_read | bus.d_write;
    // On contention the side that was not served last wins.
    assign grant_i = req_i & (~req_d | last_grant_q);
    assign grant_d = req_d & ~grant_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // NOTE: every signal gets a default at the top of the block, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                mem_be_d    = '0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                if (grant_i) begin
                    state_d      = BUSY_I;
                    last_grant_d = 1'b0;
                    mem_read_d   = 1'b1;
                    mem_be_d     = 4'b1111;
                    mem_addr_d   = bus.i_address;
                end else if (grant_d) begin
                    // A simultaneous read and write is resolved as a write.
                    state_d      = BUSY_D;
                    last_grant_d = 1'b1;
                    mem_write_d  = bus.d_write;
                    mem_read_d   = ~bus.d_write;
                    mem_be_d     = bus.d_byte_enable;
                    mem_addr_d   = bus.d_address;
                    mem_wdata_d  = bus.d_wdata;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_resp) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_be_d    = '0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                mem_be_d    = '0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
            end
        endcase
    end

    // Completion is routed combinationally so the requester sees zero added latency.
    always_comb begin
        bus.i_resp  = (state_q == BUSY_I) && bus.mem_resp;
        bus.d_resp  = (state_q == BUSY_D) && bus.mem_resp;
        bus.i_rdata = bus.i_resp ? bus.mem_rdata : '0;
        bus.d_rdata = bus.d_resp ? bus.mem_rdata : '0;
    end

    assign bus.mem_read        = mem_read_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_byte_enable = mem_be_q;
    assign bus.mem_address     = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 time unit after a rising edge,
// and outputs are compared 1 time unit after that, well away from the next edge.
module tb_mem_arbiter;

    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mem_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_read        = 1'b0;
        bus.i_address     = '0;
        bus.d_read        = 1'b0;
        bus.d_write       = 1'b0;
        bus.d_byte_enable = '0;
        bus.d_address     = '0;
        bus.d_wdata       = '0;
        bus.mem_resp      = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", bus.mem_read); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", bus.mem_write); end
        checks++; if (bus.mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address: got %h want 0", bus.mem_address); end
        checks++; if ({bus.mem_byte_enable, bus.mem_wdata} !== 36'h0) begin errors++; $display("FAIL reset_be_wdata: got %h/%h want 0/0", bus.mem_byte_enable, bus.mem_wdata); end
        checks++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b want 00", {bus.i_resp, bus.d_resp}); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_i();
        bus.i_read    = 1'b1;
        bus.i_address = 32'h60;
        tick();
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL ifetch_strobe: got rd=%b wr=%b want rd=1 wr=0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.mem_address !== 32'h60) begin errors++; $display("FAIL ifetch_address: got %h want 00000060", bus.mem_address); end
        checks++; if (bus.mem_byte_enable !== 4'hF || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL ifetch_be_wdata: got %h/%h want f/0", bus.mem_byte_enable, bus.mem_wdata); end
        // Read data sitting on the bus without mem_resp must not leak through.
        bus.mem_rdata = 32'h13;
        tick();
        tick();
        checks++; if (bus.i_resp !== 1'b0 || bus.i_rdata !== 32'h0) begin errors++; $display("FAIL ifetch_early_resp: got resp=%b data=%h want 0/0", bus.i_resp, bus.i_rdata); end
        bus.mem_resp = 1'b1;
        #1;
        checks++; if (bus.i_resp !== 1'b1 || bus.i_rdata !== 32'h13) begin errors++; $display("FAIL ifetch_resp: got resp=%b data=%h want 1/00000013", bus.i_resp, bus.i_rdata); end
        checks++; if (bus.d_resp !== 1'b0 || bus.d_rdata !== 32'h0) begin errors++; $display("FAIL ifetch_d_quiet: got resp=%b data=%h want 0/0", bus.d_resp, bus.d_rdata); end
        tick();
        clear_inputs();
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_address !== 32'h0 || bus.mem_byte_enable !== 4'h0) begin errors++; $display("FAIL ifetch_clear: got rd=%b addr=%h be=%h want 0/0/0", bus.mem_read, bus.mem_address, bus.mem_byte_enable); end
        tick();
    endtask

    task automatic test_d_write();
        bus.d_write       = 1'b1;
        bus.d_address     = 32'h100;
        bus.d_wdata       = 32'hDEADBEEF;
        bus.d_byte_enable = 4'b0011;
        tick();
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL dwrite_strobe: got wr=%b rd=%b want wr=1 rd=0", bus.mem_write, bus.mem_read); end
        checks++; if (bus.mem_address !== 32'h100 || bus.mem_wdata !== 32'hDEADBEEF || bus.mem_byte_enable !== 4'b0011) begin errors++; $display("FAIL dwrite_payload: got %h/%h/%h want 00000100/deadbeef/3", bus.mem_address, bus.mem_wdata, bus.mem_byte_enable); end
        tick();
        bus.mem_resp = 1'b1;
        #1;
        checks++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin errors++; $display("FAIL dwrite_resp: got d=%b i=%b want d=1 i=0", bus.d_resp, bus.i_resp); end
        tick();
        clear_inputs();
        checks++; if (bus.mem_write !== 1'b0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL dwrite_clear: got wr=%b wdata=%h want 0/0", bus.mem_write, bus.mem_wdata); end
        tick();
    endtask

    task automatic test_contention();
        logic [WIDTH-1:0] exp_addr;
        logic [WIDTH-1:0] rdata;
        logic             exp_i;
        rst_n         = 1'b0;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h200;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h300;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp_i    = (n % 2 == 0);
            exp_addr = exp_i ? 32'h200 : 32'h300;
            rdata    = 32'hA000_0000 + n;
            tick();
            checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== exp_addr) begin errors++; $display("FAIL contend_grant%0d: got rd=%b addr=%h want rd=1 addr=%h", n, bus.mem_read, bus.mem_address, exp_addr); end
            tick();
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = rdata;
            #1;
            checks++; if (bus.i_resp !== exp_i || bus.d_resp !== !exp_i) begin errors++; $display("FAIL contend_route%0d: got i=%b d=%b want i=%b d=%b", n, bus.i_resp, bus.d_resp, exp_i, !exp_i); end
            checks++; if ((exp_i ? bus.i_rdata : bus.d_rdata) !== rdata) begin errors++; $display("FAIL contend_rdata%0d: got i=%h d=%h want %h", n, bus.i_rdata, bus.d_rdata, rdata); end
            tick();
            bus.mem_resp = 1'b0;
            checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL contend_idle%0d: got rd=%b want 0", n, bus.mem_read); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.d_write       = 1'b1;
        bus.d_address     = 32'h400;
        bus.d_wdata       = 32'h1234_5678;
        bus.d_byte_enable = 4'hF;
        tick();
        checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got wr=%b want 1", bus.mem_write); end
        rst_n        = 1'b0;
        bus.mem_resp = 1'b1;
        #1;
        checks++; if ({bus.mem_read, bus.mem_write, bus.mem_byte_enable} !== 6'h0 || bus.mem_address !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rstmid_async_clear: got rd=%b wr=%b be=%h addr=%h wdata=%h want all 0", bus.mem_read, bus.mem_write, bus.mem_byte_enable, bus.mem_address, bus.mem_wdata); end
        checks++; if (bus.d_resp !== 1'b0 || bus.d_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_no_resp: got resp=%b data=%h want 0/0", bus.d_resp, bus.d_rdata); end
        clear_inputs();
        bus.i_read    = 1'b1;
        bus.i_address = 32'h440;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h480;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h440) begin errors++; $display("FAIL rstmid_first_grant: got rd=%b addr=%h want rd=1 addr=00000440", bus.mem_read, bus.mem_address); end
        bus.mem_resp = 1'b1;
        #1;
        checks++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0) begin errors++; $display("FAIL rstmid_first_resp: got i=%b d=%b want i=1 d=0", bus.i_resp, bus.d_resp); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_spurious_illegal();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++; if ({bus.i_resp, bus.d_resp} !== 2'b00 || bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin errors++; $display("FAIL spurious_resp: got i=%b d=%b idata=%h ddata=%h want all 0", bus.i_resp, bus.d_resp, bus.i_rdata, bus.d_rdata); end
        tick();
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL spurious_idle: got rd=%b wr=%b want 0/0", bus.mem_read, bus.mem_write); end
        clear_inputs();

        bus.d_read        = 1'b1;
        bus.d_write       = 1'b1;
        bus.d_address     = 32'h500;
        bus.d_wdata       = 32'h0BAD_F00D;
        bus.d_byte_enable = 4'b1100;
        tick();
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_address !== 32'h500) begin errors++; $display("FAIL rdwr_as_write: got wr=%b rd=%b addr=%h want wr=1 rd=0 addr=00000500", bus.mem_write, bus.mem_read, bus.mem_address); end
        bus.mem_resp = 1'b1;
        #1;
        checks++; if (bus.d_resp !== 1'b1) begin errors++; $display("FAIL rdwr_resp: got %b want 1", bus.d_resp); end
        tick();
        clear_inputs();
        tick();

        bus.i_read    = 1'b1;
        bus.i_address = 32'h600;
        tick();
        bus.i_read = 1'b0;
        tick();
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h600) begin errors++; $display("FAIL idrop_hold1: got rd=%b addr=%h want rd=1 addr=00000600", bus.mem_read, bus.mem_address); end
        tick();
        checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL idrop_hold2: got rd=%b want 1", bus.mem_read); end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h0000_0600;
        #1;
        checks++; if (bus.i_resp !== 1'b1 || bus.i_rdata !== 32'h600) begin errors++; $display("FAIL idrop_resp: got resp=%b data=%h want 1/00000600", bus.i_resp, bus.i_rdata); end
        tick();
        clear_inputs();
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL idrop_clear: got rd=%b want 0", bus.mem_read); end
        tick();
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL idrop_no_regrant: got rd=%b wr=%b want 0/0", bus.mem_read, bus.mem_write); end
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_d_write();
        test_contention();
        test_reset_mid();
        test_spurious_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
